// File: rtl/binary_game_core_pkg.sv
// Shared definitions for the binary-number game engine: state encodings,
// LFSR tap mask and the per-level round-time rule.
package binary_game_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Round time for a level: start time minus the per-level step, never below the floor
  function automatic int round_time(input int lvl, input int start_t,
                                    input int step_t, input int min_t);
    int dec;
    dec = lvl * step_t;
    if (dec >= start_t) begin
      return min_t;
    end else if ((start_t - dec) < min_t) begin
      return min_t;
    end else begin
      return start_t - dec;
    end
  endfunction

endpackage

// File: rtl/binary_game_core_if.sv
// Player/display side of the game engine: button pulses and switches in,
// target, timer, score and event pulses out.
interface binary_game_core_if #(
  parameter int NUM_W  = 4,
  parameter int TIME_W = 5
);
  logic              start;
  logic              guess;
  logic [NUM_W-1:0]  switch;
  logic [NUM_W-1:0]  target;
  logic [TIME_W-1:0] timeleft;
  logic [7:0]        level;
  logic [2:0]        lives;
  logic [1:0]        state;
  logic              hit;
  logic              miss;

  modport master (
    output start, guess, switch,
    input  target, timeleft, level, lives, state, hit, miss
  );

  modport slave (
    input  start, guess, switch,
    output target, timeleft, level, lives, state, hit, miss
  );
endinterface

// File: rtl/binary_game_core_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only the low OUT_W bits are exported.
module binary_game_core_lfsr16
  import binary_game_core_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] out
);

  logic [15:0] lfsr_r;

  // Shift one position every clock, feeding back the XOR of the tapped bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
    end
  end

  assign out = lfsr_r[OUT_W-1:0];

endmodule

// File: rtl/binary_game_core.sv
// Binary-number game engine: draws targets, runs the per-round countdown,
// judges guesses and tracks level, lives and win/loss.
module binary_game_core
  import binary_game_core_pkg::*;
#(
  parameter int          NUM_W         = 4,
  parameter int          LEVELS        = 8,
  parameter int          LIVES         = 3,
  parameter int          TIME_W        = 5,
  parameter int          START_TIME    = 20,
  parameter int          TIME_STEP     = 2,
  parameter int          MIN_TIME      = 3,
  parameter int          TICKS_PER_SEC = 50000000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  binary_game_core_if.slave  gif
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TIME_W-1:0] RT_FIRST =
    TIME_W'(round_time(0, START_TIME, TIME_STEP, MIN_TIME));

  state_t              state_r;
  logic [NUM_W-1:0]    target_r;
  logic [TIME_W-1:0]   timeleft_r;
  logic [7:0]          level_r;
  logic [2:0]          lives_r;
  logic                hit_r;
  logic                miss_r;
  logic [PRESC_W-1:0]  presc_r;

  logic [NUM_W-1:0]    draw_s;
  logic                tick_s;
  logic                timeout_s;
  logic [8:0]          level_inc_s;
  logic                win_s;
  logic                last_life_s;
  logic [TIME_W-1:0]   rt_cur_s;
  logic [TIME_W-1:0]   rt_next_s;

  binary_game_core_lfsr16 #(
    .SEED  (SEED),
    .OUT_W (NUM_W)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (draw_s)
  );

  assign tick_s      = (state_r == ST_PLAY) && (presc_r == PRESC_W'(TICKS_PER_SEC - 1));
  assign timeout_s   = tick_s && (timeleft_r == TIME_W'(1));
  assign level_inc_s = {1'b0, level_r} + 9'd1;
  assign win_s       = (level_inc_s == 9'(LEVELS));
  assign last_life_s = (lives_r == 3'd1);
  assign rt_cur_s    = TIME_W'(round_time(32'(level_r), START_TIME, TIME_STEP, MIN_TIME));
  assign rt_next_s   = TIME_W'(round_time(32'(level_inc_s), START_TIME, TIME_STEP, MIN_TIME));

  // Game FSM: one event per cycle, guess takes priority over a coincident timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      target_r   <= {NUM_W{1'b0}};
      timeleft_r <= {TIME_W{1'b0}};
      level_r    <= 8'd0;
      lives_r    <= 3'(LIVES);
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      presc_r    <= {PRESC_W{1'b0}};
    end else begin
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_WIN, ST_OVER: begin
          if (gif.start) begin
            state_r    <= ST_PLAY;
            level_r    <= 8'd0;
            lives_r    <= 3'(LIVES);
            target_r   <= draw_s;
            timeleft_r <= RT_FIRST;
            presc_r    <= {PRESC_W{1'b0}};
          end
        end
        ST_PLAY: begin
          presc_r <= tick_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
          if (gif.guess && (gif.switch == target_r)) begin
            hit_r   <= 1'b1;
            level_r <= level_inc_s[7:0];
            if (win_s) begin
              // timer and target freeze on the final value
              state_r <= ST_WIN;
            end else begin
              target_r   <= draw_s;
              timeleft_r <= rt_next_s;
              presc_r    <= {PRESC_W{1'b0}};
            end
          end else if (gif.guess || timeout_s) begin
            miss_r  <= 1'b1;
            lives_r <= lives_r - 3'd1;
            if (last_life_s) begin
              state_r <= ST_OVER;
            end else begin
              target_r   <= draw_s;
              timeleft_r <= rt_cur_s;
              presc_r    <= {PRESC_W{1'b0}};
            end
          end else if (tick_s) begin
            timeleft_r <= timeleft_r - TIME_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gif.target   = target_r;
  assign gif.timeleft = timeleft_r;
  assign gif.level    = level_r;
  assign gif.lives    = lives_r;
  assign gif.state    = state_r;
  assign gif.hit      = hit_r;
  assign gif.miss     = miss_r;

endmodule
